md_ctrl: RTL
============

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning busy cycles for mult/multu (legal range 1..31).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  operation request, sampled every clock.
REQ-005 SHALL have ports: op  in  3  operation code (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
REQ-006 SHALL have ports: a, b  in  32 each  rs and rt operand values.
REQ-007 SHALL have ports: flush  in  1  pipeline flush (exception or eret).
REQ-008 SHALL have ports: busy  out  1  unit occupied; decode stalls mfhi/mflo/mult-group while high.
REQ-009 SHALL have ports: done  out  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-010 SHALL have ports: hi, lo  out  32 each  architectural HI and LO registers.

Function
REQ-011 SHALL implement states IDLE, MUL and DIV; start is accepted only in IDLE with flush low.
REQ-012 SHALL write a to hi (MD_MTHI) or to lo (MD_MTLO) at the accepting edge; busy stays low.
REQ-013 SHALL, for mult/multu accepted at edge T, hold busy high for MULT_LAT cycles, write {hi,lo}=a*b (signed/unsigned) at edge T+MULT_LAT, and return to IDLE.
REQ-014 SHALL, for div/divu, run a 32-iteration radix-2 restoring divide: busy high 32 cycles; result written at edge T+32, lo=quotient, hi=remainder.
REQ-015 SHALL truncate signed quotients toward zero and give the remainder the dividend's sign; 0x80000000 / -1 gives lo=0x80000000, hi=0.
REQ-016 SHALL leave hi and lo unchanged on divide by zero; latency and the done pulse stay normal.
REQ-017 SHALL assert done for exactly the cycle after the result edge, concurrent with busy falling.
REQ-018 SHALL ignore start while busy; the requester is responsible for stalling.
REQ-019 SHALL, on flush while busy, abort and return to IDLE at the next edge with busy low, no done, and hi/lo unchanged.
REQ-020 SHALL let flush win over start in the same cycle, so the op is not accepted.
REQ-021 SHALL treat an undefined op with start as a no-op.

Reset
REQ-022 SHALL, on rst_n low, immediately force IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and divider state.
REQ-023 SHALL abort any in-flight operation on reset assertion mid-operation, with no result written.

Configuration
REQ-024 SHALL compile in divider support when macro MD_DIVIDER_EN is defined.
REQ-025 SHALL, without MD_DIVIDER_EN, omit the divider; div/divu are then accepted as one-cycle no-ops: busy stays low, done pulses, and hi/lo are unchanged.

Structure
REQ-026 SHALL place the op encodings (MD_* codes) and the divide iteration count (32) in the shared public definitions include.
REQ-027 SHALL contain one sub-module, md_div_iter, holding the iterative restoring divider (start, operands, sign flag, done, quotient, remainder).
REQ-028 SHALL use a single 6-bit down-counter shared by the MUL and DIV states.

Verification
REQ-029 SHALL cover: mthi a=0x12345678 -> next cycle hi=0x12345678, busy and done never high.
REQ-030 SHALL cover: mult a=-3, b=5 with MULT_LAT=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse.
REQ-031 SHALL cover: div a=-7, b=2 -> 32 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-032 SHALL cover: divu with b=0 after hi=lo=0xA5A5A5A5 -> after 32 cycles done pulses, hi/lo still 0xA5A5A5A5.
REQ-033 SHALL cover: flush at busy cycle 10 of a div -> busy low next cycle, no done, hi/lo unchanged; a start in the same cycle as the flush is not accepted.
REQ-034 SHALL cover: rst_n low mid-mult -> hi=lo=0 and busy=0 immediately; a start issued while busy is ignored and its result never appears.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings,
// divide iteration count, FSM state type and the restoring-divide step.
package md_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    // One radix-2 restoring step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits, record the bit.
    // Returns {remainder, quotient/dividend shift register}.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] t;
        logic        fit;
        t   = {rem, quo[31]};
        fit = (t >= {1'b0, dvs});
        if (fit) begin
            t = t - {1'b0, dvs};
        end
        return {t[31:0], quo[30:0], fit};
    endfunction

endpackage

// File: rtl/md_ctrl_div_iter.sv
// md_div_iter: iterative 32-step restoring divider on magnitudes, with the
// sign fix-up applied on the outputs. The first step is folded into the
// load edge, so 31 further steps leave the result ready.
module md_div_iter
    import md_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        step,
    input  logic        last,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic        done,
    output logic        dbz,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // Operand magnitudes for the signed case.
    always_comb begin
        mag_a = (sgn && a[31]) ? (32'd0 - a) : a;
        mag_b = (sgn && b[31]) ? (32'd0 - b) : b;
    end

    // Load, iterate, and flag completion on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= '0;
            quo_r <= '0;
            dvs_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            {rem_r, quo_r} <= div_step(32'd0, mag_a, mag_b);
            dvs_r <= mag_b;
            neg_q <= sgn && (a[31] ^ b[31]);
            neg_r <= sgn && a[31];
            dbz   <= (b == 32'd0);
            done  <= 1'b0;
        end else if (abort) begin
            done <= 1'b0;
        end else if (step) begin
            {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
            if (last) begin
                done <= 1'b1;
            end
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    always_comb begin
        quo = neg_q ? (32'd0 - quo_r) : quo_r;
        rem = neg_r ? (32'd0 - rem_r) : rem_r;
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide controller. Multiplies take MULT_LAT busy
// cycles, divides 32; one 6-bit down-counter times both.
// Build option: define MD_DIVIDER_EN to include the iterative divider;
// without it div/divu complete as one-cycle no-ops.
//
// state | meaning
// IDLE  | accepting start; mthi/mtlo write here
// MUL   | multiply in flight, counter runs to terminal count
// DIV   | divide in flight, divider steps while counter runs
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state;
    logic [5:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        msgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        accept;
    logic        div_done;
    logic        div_dbz;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign accept = (state == IDLE) && start && !flush;

`ifdef MD_DIVIDER_EN
    logic div_start;
    logic div_stepen;
    logic div_last;

    assign div_start  = accept && ((op == MD_DIV) || (op == MD_DIVU));
    assign div_stepen = (state == DIV) && !flush && (cnt != 6'd0);
    assign div_last   = (cnt == 6'd1);

    md_div_iter u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (flush),
        .step  (div_stepen),
        .last  (div_last),
        .a     (a),
        .b     (b),
        .sgn   (op == MD_DIV),
        .done  (div_done),
        .dbz   (div_dbz),
        .quo   (div_quo),
        .rem   (div_rem)
    );
`else
    assign div_done = 1'b0;
    assign div_dbz  = 1'b0;
    assign div_quo  = '0;
    assign div_rem  = '0;
`endif

    // Full 64-bit product of the captured operands; sign-extended for mult.
    always_comb begin
        ext_a = msgn ? {{32{opa[31]}}, opa} : {32'd0, opa};
        ext_b = msgn ? {{32{opb[31]}}, opb} : {32'd0, opb};
        prod  = ext_a * ext_b;
    end

    // Sequencer: accept ops in IDLE, time MUL/DIV, write HI/LO, handle flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            msgn  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            MD_MULT, MD_MULTU: begin
                                opa   <= a;
                                opb   <= b;
                                msgn  <= (op == MD_MULT);
                                cnt   <= 6'(MULT_LAT - 1);
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                            MD_DIV, MD_DIVU: begin
`ifdef MD_DIVIDER_EN
                                cnt   <= 6'(DIV_ITERS - 1);
                                busy  <= 1'b1;
                                state <= DIV;
`else
                                done  <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        if (div_done && !div_dbz) begin
                            hi <= div_rem;
                            lo <= div_quo;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
